// File: rtl/noise_burst_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : noise_pkg
//  Description : Shared types and constants for the noise burst sequencer:
//                FSM state encoding, default lane geometry, seed lock-up
//                substitute value and the per-lane seed helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package noise_pkg;

    localparam int NLANES_DEFAULT   = 8;
    localparam int SAMPLE_W_DEFAULT = 16;

    // An all-zero LFSR seed would lock the generator; this value replaces it.
    localparam logic [7:0] SEED_LOCKUP_SUB = 8'h01;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEED  = 3'd1,
        S_RUN   = 3'd2,
        S_GAP   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    // Seed for lane k: (base + k) mod 256, with 0 replaced by the lock-up substitute.
    function automatic logic [7:0] seed_value(input logic [7:0] base, input logic [7:0] lane);
        logic [7:0] s;
        s = base + lane;
        return (s == 8'h00) ? SEED_LOCKUP_SUB : s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/noise_burst_sequencer_out_reg.sv
`default_nettype none
// ============================================================================
//  Module      : noise_out_reg
//  Description : Single-stage AXI-Stream holding register. A load captures a
//                word and its last flag; the word is held unchanged until the
//                downstream side accepts it.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                load, load_data,
//                load_last          - capture request with payload
//                can_load           - register empty or being emptied now
//                tdata/tvalid/tlast - stream outputs; tready - stream input
//  Revision    : 1.0 - initial release
// ============================================================================
module noise_out_reg #(
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              can_load,
    output logic [DATA_W-1:0] tdata,
    output logic              tvalid,
    output logic              tlast,
    input  logic              tready
);

    assign can_load = !tvalid || tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            tdata  <= '0;
            tvalid <= 1'b0;
            tlast  <= 1'b0;
        end else if (load) begin
            tdata  <= load_data;
            tvalid <= 1'b1;
            tlast  <= load_last;
        end else if (tready) begin
            // Data is left in place; only the qualifiers drop after acceptance.
            tvalid <= 1'b0;
            tlast  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/noise_burst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : noise_burst_sequencer
//  Description : Seeds NLANES generator LFSRs, then streams bursts of
//                generator samples over AXI-Stream, optionally repeating
//                bursts separated by idle gaps until stopped.
//  Ports       : clk, rst                      - clock, sync active-high reset
//                start, stop, continuous,
//                burst_len, gap_len, seed_base - control / configuration
//                gen_enable, seed_dv, seed_data,
//                gen_data                      - generator interface
//                m_tdata/m_tvalid/m_tready/
//                m_tlast                       - output stream
//                busy, cfg_err                 - status
//  Revision    : 1.0 - initial release
// ============================================================================
module noise_burst_sequencer
    import noise_pkg::*;
#(
    parameter int NLANES   = NLANES_DEFAULT,
    parameter int SAMPLE_W = SAMPLE_W_DEFAULT,
    parameter int LEN_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       continuous,
    input  logic [LEN_W-1:0]           burst_len,
    input  logic [LEN_W-1:0]           gap_len,
    input  logic [7:0]                 seed_base,
    output logic                       gen_enable,
    output logic [NLANES-1:0]          seed_dv,
    output logic [7:0]                 seed_data,
    input  logic [NLANES*SAMPLE_W-1:0] gen_data,
    output logic [NLANES*SAMPLE_W-1:0] m_tdata,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic                       m_tlast,
    output logic                       busy,
    output logic                       cfg_err
);

    localparam int                DATA_W    = NLANES * SAMPLE_W;
    localparam int                LANE_W    = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NLANES - 1);
    localparam logic [LEN_W-1:0]  ONE       = LEN_W'(1);

    state_t            state;
    state_t            state_nxt;
    logic [LANE_W-1:0] lane_cnt;
    logic [LEN_W-1:0]  beat_cnt;
    logic [LEN_W-1:0]  gap_cnt;
    logic [LEN_W-1:0]  cfg_len;
    logic [LEN_W-1:0]  cfg_gap;
    logic              cfg_cont;
    logic [7:0]        cfg_seed;
    logic              stop_seen;
    logic              can_load;
    logic              first_beat;
    logic              load_last;
    logic              accept_start;
    logic              start_req;

    // stop has priority over a simultaneous start.
    assign start_req = start && !stop;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and generator-side outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        gen_enable   = 1'b0;
        first_beat   = 1'b0;
        seed_dv      = '0;
        seed_data    = 8'h00;
        accept_start = 1'b0;

        case (state)
            S_IDLE: begin
                if (start_req && (burst_len != '0)) begin
                    accept_start = 1'b1;
                    state_nxt    = S_SEED;
                end
            end

            S_SEED: begin
                seed_dv[lane_cnt] = 1'b1;
                seed_data         = seed_value(cfg_seed, 8'(lane_cnt));
                if (lane_cnt == LAST_LANE) begin
                    state_nxt = S_RUN;
                end
            end

            S_RUN: begin
                if (can_load && (beat_cnt < cfg_len)) begin
                    gen_enable = 1'b1;
                    if (beat_cnt == cfg_len - ONE) begin
                        state_nxt = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                // can_load here means the final beat is leaving (or has left).
                if (can_load) begin
                    if (!cfg_cont || stop_seen || stop) begin
                        state_nxt = S_IDLE;
                    end else if (cfg_gap != '0) begin
                        state_nxt = S_GAP;
                    end else begin
                        // Back-to-back: issue beat 0 of the next burst while the
                        // previous last beat is accepted, so no bubble appears.
                        gen_enable = 1'b1;
                        first_beat = 1'b1;
                        state_nxt  = (cfg_len == ONE) ? S_DRAIN : S_RUN;
                    end
                end
            end

            S_GAP: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                end else if (gap_cnt == cfg_gap - ONE) begin
                    // Prefetch beat 0 in the last gap cycle so the stream shows
                    // exactly gap_len invalid cycles between bursts.
                    gen_enable = 1'b1;
                    first_beat = 1'b1;
                    state_nxt  = (cfg_len == ONE) ? S_DRAIN : S_RUN;
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

    assign load_last = first_beat ? (cfg_len == ONE) : (beat_cnt == cfg_len - ONE);
    assign busy      = (state != S_IDLE);

    // ------------------------------------------------------------------------
    // Counters, configuration capture, stop latch and error flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_cnt  <= '0;
            beat_cnt  <= '0;
            gap_cnt   <= '0;
            cfg_len   <= '0;
            cfg_gap   <= '0;
            cfg_cont  <= 1'b0;
            cfg_seed  <= 8'h00;
            stop_seen <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            lane_cnt <= ((state == S_SEED) && (lane_cnt != LAST_LANE)) ?
                        lane_cnt + LANE_W'(1) : '0;
            gap_cnt  <= (state == S_GAP) ? gap_cnt + ONE : '0;

            if (gen_enable) begin
                beat_cnt <= first_beat ? ONE : beat_cnt + ONE;
            end else if (state == S_SEED) begin
                beat_cnt <= '0;
            end

            if (state == S_IDLE) begin
                stop_seen <= 1'b0;
            end else if (stop) begin
                stop_seen <= 1'b1;
            end

            if (accept_start) begin
                cfg_len  <= burst_len;
                cfg_gap  <= gap_len;
                cfg_cont <= continuous;
                cfg_seed <= seed_base;
                cfg_err  <= 1'b0;
            end else if ((state == S_IDLE) && start_req && (burst_len == '0)) begin
                cfg_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output holding register
    // ------------------------------------------------------------------------
    noise_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (gen_enable),
        .load_data (gen_data),
        .load_last (load_last),
        .can_load  (can_load),
        .tdata     (m_tdata),
        .tvalid    (m_tvalid),
        .tlast     (m_tlast),
        .tready    (m_tready)
    );

endmodule
`default_nettype wire

// File: tb/tb_noise_burst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_noise_burst_sequencer
//  Description : Self-checking bench for noise_burst_sequencer. Seed
//                sequences are table driven; stalls, continuous mode with
//                stop, configuration error and mid-burst reset are directed
//                sequences. A scoreboard tracks every generator word and the
//                expected last flag through to acceptance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_noise_burst_sequencer;

    localparam int NLANES   = 8;
    localparam int SAMPLE_W = 16;
    localparam int LEN_W    = 16;
    localparam int DW       = NLANES * SAMPLE_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              stop;
    logic              continuous;
    logic [LEN_W-1:0]  burst_len;
    logic [LEN_W-1:0]  gap_len;
    logic [7:0]        seed_base;
    logic              gen_enable;
    logic [NLANES-1:0] seed_dv;
    logic [7:0]        seed_data;
    logic [DW-1:0]     gen_data;
    logic [DW-1:0]     m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;
    logic              busy;
    logic              cfg_err;

    logic [15:0]       cyc = 16'h0;

    int checks   = 0;
    int errors   = 0;
    int ge_count = 0;
    int accepts  = 0;
    int cur_len  = 1;
    int push_idx = 0;
    logic [DW:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 16'h1;

    // Every cycle presents a distinct generator word.
    assign gen_data = {NLANES{cyc}};

    noise_burst_sequencer #(
        .NLANES   (NLANES),
        .SAMPLE_W (SAMPLE_W),
        .LEN_W    (LEN_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .burst_len  (burst_len),
        .gap_len    (gap_len),
        .seed_base  (seed_base),
        .gen_enable (gen_enable),
        .seed_dv    (seed_dv),
        .seed_data  (seed_data),
        .gen_data   (gen_data),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .busy       (busy),
        .cfg_err    (cfg_err)
    );

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic start_seq(input int len, input int gap, input logic cont, input logic [7:0] base);
        cur_len    = len;
        burst_len  = LEN_W'(len);
        gap_len    = LEN_W'(gap);
        continuous = cont;
        seed_base  = base;
        start      = 1'b1;
        step;
        start      = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while (busy && n < maxc) begin
            step;
            n++;
        end
        chk("idle_timeout", busy, 1'b0);
    endtask

    task automatic chk_outs_zero(input string pfx);
        chk({pfx, "_gen_enable"}, gen_enable, 1'b0);
        chk({pfx, "_seed_dv"},    seed_dv,    '0);
        chk({pfx, "_seed_data"},  seed_data,  8'h00);
        chk({pfx, "_m_tdata"},    m_tdata,    '0);
        chk({pfx, "_m_tvalid"},   m_tvalid,   1'b0);
        chk({pfx, "_m_tlast"},    m_tlast,    1'b0);
        chk({pfx, "_busy"},       busy,       1'b0);
        chk({pfx, "_cfg_err"},    cfg_err,    1'b0);
    endtask

    // Scoreboard: words enter when gen_enable is high and must leave, in order,
    // with m_tlast exactly on the last beat of each burst.
    initial begin
        logic [DW:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                push_idx = 0;
            end else begin
                if (m_tvalid && m_tready) begin
                    accepts++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got %0h expected none", m_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", m_tdata, e[DW-1:0]);
                        chk("beat_last", m_tlast, e[DW]);
                    end
                end
                if (gen_enable) begin
                    ge_count++;
                    exp_q.push_back({(push_idx == cur_len - 1), gen_data});
                    push_idx = (push_idx == cur_len - 1) ? 0 : push_idx + 1;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    typedef struct {
        logic [7:0]  base;
        int          len;
        logic [63:0] exp_seed;   // lane k seed in bits [8k+7:8k]
    } seed_vec_t;

    seed_vec_t vec [4];

    initial begin
        logic [7:0]  one;
        logic [14:0] exp_v;
        logic [14:0] exp_l;
        logic [14:0] exp_b;
        logic [3:0]  pat;

        vec[0] = '{8'h10, 4, 64'h17161514_13121110};
        vec[1] = '{8'hFE, 1, 64'h05040302_0101FFFE};
        vec[2] = '{8'hF9, 2, 64'h01FFFEFD_FCFBFAF9};
        vec[3] = '{8'h00, 3, 64'h07060504_03020101};

        rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
        burst_len = '0; gap_len = '0; seed_base = 8'h00; m_tready = 1'b1;
        step;
        step;
        rst = 1'b0;
        chk_outs_zero("reset");

        // ---------------- seed table with single bursts, ready held high
        for (int i = 0; i < 4; i++) begin
            ge_count = 0;
            start_seq(vec[i].len, 0, 1'b0, vec[i].base);
            for (int k = 0; k < NLANES; k++) begin
                one = 8'h01 << k;
                chk("seed_dv",   seed_dv,    one);
                chk("seed_data", seed_data,  vec[i].exp_seed[8*k +: 8]);
                chk("seed_ge",   gen_enable, 1'b0);
                chk("seed_busy", busy,       1'b1);
                step;
            end
            chk("run_entry", {gen_enable, m_tvalid}, 2'b10);
            for (int b = 0; b < vec[i].len; b++) begin
                step;
                chk("run_valid", m_tvalid, 1'b1);
                chk("run_last",  m_tlast,  (b == vec[i].len - 1));
                chk("run_busy",  busy,     1'b1);
            end
            step;
            chk("busy_fall",  busy,          1'b0);
            chk("idle_valid", m_tvalid,      1'b0);
            chk("ge_count",   ge_count,      vec[i].len);
            chk("q_empty",    exp_q.size(),  0);
        end

        // ---------------- stalls: ready pattern 1,0,0,1 repeating
        ge_count = 0;
        accepts  = 0;
        pat      = 4'b1001;
        start_seq(3, 0, 1'b0, 8'h33);
        repeat (NLANES) step;
        for (int t = 0; t < 40 && busy; t++) begin
            m_tready = pat[t % 4];
            step;
        end
        m_tready = 1'b1;
        chk("stall_idle",    busy,         1'b0);
        chk("stall_accepts", accepts,      3);
        chk("stall_ge",      ge_count,     3);
        chk("stall_q_empty", exp_q.size(), 0);

        // ---------------- continuous, gap 2, stop during second burst
        ge_count = 0;
        exp_v    = 15'h01CE;   // valid on t=1..3 and t=6..8
        exp_l    = 15'h0108;   // last on t=3 and t=8
        exp_b    = 15'h01FF;   // busy through t=8
        start_seq(3, 2, 1'b1, 8'h50);
        repeat (NLANES) step;
        for (int t = 0; t < 15; t++) begin
            chk("cont_valid", m_tvalid, exp_v[t]);
            chk("cont_last",  m_tlast,  exp_l[t]);
            chk("cont_busy",  busy,     exp_b[t]);
            stop = (t == 7);
            step;
        end
        stop = 1'b0;
        chk("cont_ge", ge_count, 6);

        // ---------------- configuration error, start/stop collision, start while busy
        burst_len = '0;
        start     = 1'b1;
        step;
        start     = 1'b0;
        chk("cfg_err_set",  cfg_err, 1'b1);
        chk("cfg_err_busy", busy,    1'b0);
        step;
        chk("cfg_err_sticky", cfg_err, 1'b1);
        burst_len = LEN_W'(2);
        start     = 1'b1;
        stop      = 1'b1;
        step;
        start     = 1'b0;
        stop      = 1'b0;
        chk("start_stop_busy", busy,    1'b0);
        chk("start_stop_err",  cfg_err, 1'b1);
        start_seq(2, 0, 1'b0, 8'h20);
        chk("cfg_err_clear", cfg_err,   1'b0);
        chk("restart_busy",  busy,      1'b1);
        chk("restart_seed0", seed_data, 8'h20);
        seed_base = 8'h80;
        start     = 1'b1;
        step;
        start     = 1'b0;
        chk("ignored_start_seed1", seed_data, 8'h21);
        chk("ignored_start_dv1",   seed_dv,   8'h02);
        wait_idle(40);
        chk("cfg_q_empty", exp_q.size(), 0);

        // ---------------- reset on beat 2 of 5, then full restart
        start_seq(5, 0, 1'b0, 8'h40);
        repeat (NLANES) step;
        step;
        step;
        step;
        chk("pre_rst_valid", m_tvalid, 1'b1);
        rst = 1'b1;
        step;
        chk_outs_zero("mid_rst");
        rst      = 1'b0;
        ge_count = 0;
        accepts  = 0;
        start_seq(5, 0, 1'b0, 8'h40);
        chk("reseed_dv",   seed_dv,   8'h01);
        chk("reseed_data", seed_data, 8'h40);
        wait_idle(60);
        chk("rst_accepts", accepts,      5);
        chk("rst_ge",      ge_count,     5);
        chk("rst_q_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/noise_burst_sequencer.md
NOISE_BURST_SEQUENCER -- requirements
Module: noise_burst_sequencer

Interface
REQ-001 Parameter NLANES, default 8: number of noise lanes and per-lane LFSRs.
REQ-002 Parameter SAMPLE_W, default 16: bits per lane sample; data width = NLANES*SAMPLE_W.
REQ-003 Parameter LEN_W, default 16: width of burst_len, gap_len and beat counters.
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse; begins a seed-then-burst sequence from IDLE.
REQ-007 stop  in  1  one-cycle pulse; requests graceful termination.
REQ-008 continuous  in  1  0 = single burst; 1 = repeat bursts separated by gaps; sampled at start.
REQ-009 burst_len  in  LEN_W  beats per burst; sampled at start.
REQ-010 gap_len  in  LEN_W  idle cycles between bursts; sampled at start.
REQ-011 seed_base  in  8  base seed value; sampled at start.
REQ-012 gen_enable  out  1  advance strobe to the Gaussian generator LFSRs.
REQ-013 seed_dv  out  NLANES  one-hot per-lane seed load strobe.
REQ-014 seed_data  out  8  seed value for the lane strobed by seed_dv.
REQ-015 gen_data  in  NLANES*SAMPLE_W  sample word from the generator, valid in the cycle gen_enable is high.
REQ-016 m_tdata  out  NLANES*SAMPLE_W  output sample word.
REQ-017 m_tvalid / m_tready / m_tlast  out/in/out  1 each  AXI-Stream handshake; m_tlast marks the last beat of a burst.
REQ-018 busy  out  1  high in any state other than IDLE.
REQ-019 cfg_err  out  1  sticky; set when start arrives with burst_len = 0; cleared by the next accepted start or by rst.

Function
REQ-020 The FSM SHALL have states IDLE, SEED, RUN, GAP, DRAIN.
REQ-021 IDLE->SEED on start when burst_len != 0; if start and stop are both high in the same cycle, stop SHALL win and the FSM SHALL remain in IDLE.
REQ-022 start with burst_len = 0 SHALL set cfg_err and leave the FSM in IDLE.
REQ-023 SEED SHALL last exactly NLANES cycles: in cycle k, seed_dv = 1<<k and seed_data = (seed_base+k) mod 256, with a value of 0 replaced by 8'h01 (LFSR lock-up avoidance); gen_enable SHALL be 0 throughout.
REQ-024 SEED->RUN after lane NLANES-1; stop during SEED SHALL be latched and take effect after the first burst.
REQ-025 In RUN, gen_enable SHALL be high exactly when (!m_tvalid || m_tready) and beats issued < burst_len; in that cycle gen_data SHALL be registered into m_tdata and m_tvalid set (1-cycle latency).
REQ-026 m_tdata, m_tvalid and m_tlast SHALL hold stable while m_tvalid && !m_tready; no sample SHALL be dropped or duplicated.
REQ-027 m_tlast SHALL be 1 on beat burst_len-1 (zero-based) only; burst_len = 1 yields a single beat with m_tlast = 1.
REQ-028 After the last beat is issued: RUN->DRAIN; DRAIN waits until the last beat is accepted.
REQ-029 DRAIN exit: ->IDLE if continuous = 0 or stop has been latched; else ->GAP if gap_len != 0; else ->RUN directly (back-to-back bursts with no reseed).
REQ-030 GAP SHALL count gap_len cycles with m_tvalid = 0, then ->RUN; stop in GAP SHALL force ->IDLE on the next cycle.
REQ-031 stop in RUN SHALL be latched; the current burst SHALL complete, including m_tlast.
REQ-032 start while busy SHALL be ignored.
REQ-033 The beat and gap counters SHALL be LEN_W bits wide and SHALL reset to 0 at each burst or gap entry; no wrap is possible because burst_len <= 2^LEN_W-1.

Reset
REQ-034 On rst: FSM -> IDLE; gen_enable = 0, seed_dv = 0, seed_data = 0, m_tdata = 0, m_tvalid = 0, m_tlast = 0, busy = 0, cfg_err = 0; latched stop and configuration cleared; all on the cycle after rst is sampled high.
REQ-035 rst asserted mid-burst SHALL abort the burst without emitting m_tlast; the next start SHALL reseed the generator.

Structure
REQ-036 Package noise_pkg SHALL hold the state enum type, NLANES and SAMPLE_W defaults, and the SEED_LOCKUP_SUB constant 8'h01.
REQ-037 One sub-module is natural: noise_out_reg, a single-stage valid/ready holding register; all other logic is flat.

Verification
REQ-038 burst_len=4, continuous=0, m_tready=1, seed_base=8'h10 -> seed_dv 01..80 with seed_data 10..17; then 4 beats on consecutive cycles, m_tlast on beat 3; busy falls 1 cycle after the last accept.
REQ-039 seed_base=8'hFE -> seed_data sequence FE, FF, 01, 01, 02, 03, 04, 05 (wrapped value 00 replaced by 01).
REQ-040 burst_len=3, m_tready toggling 1,0,0,1,... -> exactly 3 distinct words, each held while stalled, gen_enable pulse count = 3.
REQ-041 continuous=1, gap_len=2, stop pulsed mid second burst -> second burst completes with m_tlast, then IDLE, no third burst; gap between bursts = 2 cycles with m_tvalid=0.
REQ-042 start with burst_len=0 -> cfg_err=1, busy=0; a subsequent valid start clears cfg_err.
REQ-043 rst asserted on beat 2 of 5 -> all outputs 0 on the next cycle, no m_tlast; a new start reseeds and delivers 5 beats.
